gyro_integrator: RTL and testbench
==================================

# gyro_integrator

Multi-axis angle integrator for the gyro front end: accepts a vector of signed angular-rate samples, accumulates each axis into an angle held in [0, FULL_SCALE-1] with correct wrap in both directions, and publishes the updated angle vector with a valid strobe. It is the parametrised successor of the single-axis x-angle accumulator. Axes share one adder through a sequencing FSM. Optional bias calibration subtracts a measured per-axis zero-rate offset.

## Interface
- NUM_AXES, 3, number of axes (1..8)
- DATA_W, 16, rate sample width, two's complement
- ANGLE_W, 16, angle width, unsigned
- FULL_SCALE, 360, wrap modulus; must be < 2^(ANGLE_W-1)
- SHIFT, 0, arithmetic right shift applied to each rate sample (scaling)
- CAL_LOG2, 4, calibration averages 2^CAL_LOG2 samples
- clk  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- in_valid  in  1  sample vector valid
- in_ready  out  1  block accepts a vector this cycle
- in_data  in  NUM_AXES*DATA_W  rate vector, axis 0 in LSBs
- zero  in  1  clear all angles (synchronous command)
- out_valid  out  1  one-cycle strobe, angle vector updated
- angle  out  NUM_AXES*ANGLE_W  current angles, axis 0 in LSBs
- wrap_flag  out  NUM_AXES  per-axis sticky-per-update: axis wrapped during last update
- cal_start, cal_busy  in/out  1  only with GYRO_BIAS_CAL_EN

## Operation
- States: IDLE, ADD, NORM, DONE (plus CAL with macro).
- in_ready = (state==IDLE) && !zero. Transfer on in_valid && in_ready: latch in_data, axis index = 0, clear wrap_flag, go ADD.
- ADD: sum = angle[i] + ((in_data[i] >>> SHIFT) - bias[i]); SUM_W = max(ANGLE_W, DATA_W) + 2, all sign-extended. Go NORM.
- NORM (one correction per cycle): sum < 0 -> sum += FULL_SCALE, wrap_flag[i]=1, stay; sum >= FULL_SCALE -> sum -= FULL_SCALE, wrap_flag[i]=1, stay; else angle[i] <= sum; next axis -> ADD, last axis -> DONE.
- DONE: out_valid=1 for one cycle, -> IDLE. angle outputs change only on NORM write-back; partial vector visible mid-update is permitted, consumers sample on out_valid.
- Exactly FULL_SCALE-1 stays; exactly FULL_SCALE becomes 0; -1 becomes FULL_SCALE-1.
- zero in IDLE: all angles and wrap_flag cleared next edge, no out_valid. zero in any other state: abort, clear angles, -> IDLE, no out_valid for the aborted vector.
- Reset: state IDLE, angle all 0, wrap_flag 0, out_valid 0, in_ready 1 after deassertion, bias 0, cal_busy 0.

## Timing
- Acceptance at edge E0; out_valid high in the cycle after edge E0 + 2*NUM_AXES + K + 1, K = total NORM corrections. |rate| < FULL_SCALE gives K <= NUM_AXES.
- Minimum spacing between accepted vectors: 2*NUM_AXES + K + 2 cycles.
- Input vector held internally after transfer; in_data may change freely.
- RST is asynchronous on assertion; deassertion is synchronised externally.

## Configuration
- GYRO_BIAS_CAL_EN defined: cal_start (in IDLE, zero low) -> CAL, cal_busy=1. In CAL, in_ready=1; each accepted vector adds to per-axis accumulators (DATA_W+CAL_LOG2 bits); after 2^CAL_LOG2 samples bias[i] = acc >>> CAL_LOG2, -> IDLE, cal_busy=0. Angles unchanged, no out_valid during CAL. zero during CAL aborts, bias unchanged. cal_start outside IDLE ignored.
- Not defined: bias is constant 0, no CAL state, cal_start/cal_busy ports absent.

## Structure
- gyro_pkg: state enum, SUM_W computation function, sign-extend helper.
- Sub-module gyro_bias_cal: per-axis accumulators, sample counter, bias registers; instantiated only under GYRO_BIAS_CAL_EN.

## Test plan
- Reset, NUM_AXES=3, FULL_SCALE=360: vector (10, 20, 30) -> angles (10, 20, 30), wrap_flag 000, out_valid 7 cycles after transfer edge.
- Angle axis0 = 350, rate +15 -> 5, wrap_flag[0]=1; rate -20 from 5 -> 345, wrap_flag[0]=1.
- Angle 0, rate +720 (DATA_W=16) -> 0 after two corrections, latency grows by 2 cycles.
- zero asserted in NORM of axis 1 -> all angles 0, no out_valid, in_ready high next cycle.
- RST low mid-ADD -> outputs immediately reset values, next vector (1, 1, 1) -> (1, 1, 1).
- With GYRO_BIAS_CAL_EN, CAL_LOG2=2: four vectors (3, -2, 0) -> bias (3, -2, 0); then vector (3, -2, 5) -> angles (0, 0, 5).

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared types and elaboration helpers for the gyro angle integrator.
// The state enum carries the calibration state unconditionally; it is only reachable with GYRO_BIAS_CAL_EN.
package gyro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_NORM,
        ST_DONE,
        ST_CAL
    } state_t;

    // Two guard bits hold angle + rate - bias without overflow for either sign.
    function automatic int sum_width(input int angle_w, input int data_w);
        return ((angle_w > data_w) ? angle_w : data_w) + 2;
    endfunction

    // Sign-extends the low w bits of v to 64 bits; callers cast down to their working width.
    function automatic logic signed [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/gyro_bias_cal.sv
// Zero-rate bias measurement: averages 2^CAL_LOG2 rate vectors per axis into bias registers.
// The bias registers keep their value until the next completed calibration run.
module gyro_bias_cal
    import gyro_pkg::*;
#(
    parameter int NUM_AXES = 3,
    parameter int DATA_W   = 16,
    parameter int CAL_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       start,
    input  logic                       sample,
    input  logic [NUM_AXES*DATA_W-1:0] sample_data,
    output logic                       done,
    output logic [NUM_AXES*DATA_W-1:0] bias
);

    localparam int ACC_W = DATA_W + CAL_LOG2;
    localparam int CNT_W = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << CAL_LOG2) - 1);

    logic signed [ACC_W-1:0] acc     [NUM_AXES];
    logic signed [ACC_W-1:0] acc_sum [NUM_AXES];
    logic [CNT_W-1:0]        cnt;

    assign done = sample && (cnt == LAST_CNT);

    always_comb begin
        for (int i = 0; i < NUM_AXES; i++) begin
            acc_sum[i] = acc[i] + ACC_W'(sext(64'(sample_data[i*DATA_W +: DATA_W]), DATA_W));
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt  <= '0;
            bias <= '0;
            for (int i = 0; i < NUM_AXES; i++) acc[i] <= '0;
        end else if (start) begin
            cnt <= '0;
            for (int i = 0; i < NUM_AXES; i++) acc[i] <= '0;
        end else if (sample) begin
            cnt <= cnt + 1'b1;
            for (int i = 0; i < NUM_AXES; i++) begin
                acc[i] <= acc_sum[i];
                if (done) bias[i*DATA_W +: DATA_W] <= DATA_W'(acc_sum[i] >>> CAL_LOG2);
            end
        end
    end

endmodule

// File: rtl/gyro_integrator.sv
// Multi-axis angle integrator: one shared adder walks the axes, wrapping each angle into [0, FULL_SCALE-1].
// Define GYRO_BIAS_CAL_EN to add the bias-calibration state, cal_start/cal_busy ports and gyro_bias_cal.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int NUM_AXES   = 3,
    parameter int DATA_W     = 16,
    parameter int ANGLE_W    = 16,
    parameter int FULL_SCALE = 360,
    parameter int SHIFT      = 0
`ifdef GYRO_BIAS_CAL_EN
    ,
    parameter int CAL_LOG2   = 4
`endif
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_AXES*DATA_W-1:0]  in_data,
    input  logic                        zero,
`ifdef GYRO_BIAS_CAL_EN
    input  logic                        cal_start,
    output logic                        cal_busy,
`endif
    output logic                        out_valid,
    output logic [NUM_AXES*ANGLE_W-1:0] angle,
    output logic [NUM_AXES-1:0]         wrap_flag
);

    localparam int SUM_W  = sum_width(ANGLE_W, DATA_W);
    localparam int AXIS_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam logic signed [SUM_W-1:0] FS        = SUM_W'(FULL_SCALE);
    localparam logic [AXIS_W-1:0]       LAST_AXIS = AXIS_W'(NUM_AXES - 1);

    state_t                    state, state_next;
    logic [NUM_AXES*DATA_W-1:0] data_q;
    logic [AXIS_W-1:0]         axis_q;
    logic signed [SUM_W-1:0]   sum_q;
    logic [ANGLE_W-1:0]        angle_q [NUM_AXES];
    logic signed [SUM_W-1:0]   rate_ext, bias_ext, angle_ext;
    logic                      accept, sum_neg, sum_over, out_valid_next;

    assign accept   = in_valid && in_ready;
    assign sum_neg  = sum_q[SUM_W-1];
    assign sum_over = !sum_neg && (sum_q >= FS);

    assign rate_ext  = SUM_W'(sext(64'(data_q[axis_q*DATA_W +: DATA_W]), DATA_W) >>> SHIFT);
    assign angle_ext = SUM_W'(angle_q[axis_q]);

`ifdef GYRO_BIAS_CAL_EN
    logic [NUM_AXES*DATA_W-1:0] bias_vec;
    logic                       cal_done;

    gyro_bias_cal #(
        .NUM_AXES (NUM_AXES),
        .DATA_W   (DATA_W),
        .CAL_LOG2 (CAL_LOG2)
    ) u_bias_cal (
        .clk         (clk),
        .RST         (RST),
        .start       ((state == ST_IDLE) && !zero && !accept && cal_start),
        .sample      ((state == ST_CAL) && accept),
        .sample_data (in_data),
        .done        (cal_done),
        .bias        (bias_vec)
    );

    assign bias_ext = SUM_W'(sext(64'(bias_vec[axis_q*DATA_W +: DATA_W]), DATA_W));
    assign cal_busy = (state == ST_CAL);
`else
    assign bias_ext = '0;
`endif

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_next;
    end

    // NOTE: every signal assigned in a combinational process gets a default first, so no path leaves it holding and infers a latch.
    always_comb begin
        state_next = state;
        if (zero) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state_next = ST_ADD;
`ifdef GYRO_BIAS_CAL_EN
                    else if (cal_start) state_next = ST_CAL;
`endif
                end
                ST_ADD:  state_next = ST_NORM;
                ST_NORM: begin
                    if (!sum_neg && !sum_over) state_next = (axis_q == LAST_AXIS) ? ST_DONE : ST_ADD;
                end
                ST_DONE: state_next = ST_IDLE;
`ifdef GYRO_BIAS_CAL_EN
                ST_CAL:  if (cal_done) state_next = ST_IDLE;
`endif
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready       = ((state == ST_IDLE) || (state == ST_CAL)) && !zero;
        out_valid_next = (state == ST_DONE) && !zero;
    end

    // NOTE: the per-axis angle array is only NUM_AXES words, so it is reset like ordinary registers rather than left to a clear sequence.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            data_q    <= '0;
            axis_q    <= '0;
            sum_q     <= '0;
            wrap_flag <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) angle_q[i] <= '0;
        end else begin
            out_valid <= out_valid_next;
            if (zero) begin
                wrap_flag <= '0;
                for (int i = 0; i < NUM_AXES; i++) angle_q[i] <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (accept) begin
                        data_q    <= in_data;
                        axis_q    <= '0;
                        wrap_flag <= '0;
                    end
                    ST_ADD: sum_q <= angle_ext + rate_ext - bias_ext;
                    ST_NORM: begin
                        // One modulus correction per cycle keeps the adder path to a single add.
                        if (sum_neg) begin
                            sum_q             <= sum_q + FS;
                            wrap_flag[axis_q] <= 1'b1;
                        end else if (sum_over) begin
                            sum_q             <= sum_q - FS;
                            wrap_flag[axis_q] <= 1'b1;
                        end else begin
                            angle_q[axis_q] <= ANGLE_W'(sum_q);
                            axis_q          <= axis_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_angle
        assign angle[g*ANGLE_W +: ANGLE_W] = angle_q[g];
    end

endmodule

// File: tb/tb_gyro_integrator.sv
// Self-checking bench for gyro_integrator: directed table, hand-written abort/reset sequences and
// randomized vectors against a modular-arithmetic reference model.
module tb_gyro_integrator;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int FSC = 360;

    logic              clk = 1'b0;
    logic              RST = 1'b0;
    logic              in_valid = 1'b0;
    logic              zero = 1'b0;
    logic [N*DW-1:0]   in_data = '0;
    logic              in_ready, out_valid;
    logic [N*AW-1:0]   angle;
    logic [N-1:0]      wrap_flag;
`ifdef GYRO_BIAS_CAL_EN
    logic              cal_start = 1'b0;
    logic              cal_busy;
`endif

    gyro_integrator #(
        .NUM_AXES   (N),
        .DATA_W     (DW),
        .ANGLE_W    (AW),
        .FULL_SCALE (FSC),
        .SHIFT      (0)
`ifdef GYRO_BIAS_CAL_EN
        ,
        .CAL_LOG2   (2)
`endif
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .zero      (zero),
`ifdef GYRO_BIAS_CAL_EN
        .cal_start (cal_start),
        .cal_busy  (cal_busy),
`endif
        .out_valid (out_valid),
        .angle     (angle),
        .wrap_flag (wrap_flag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int model_ang [N];

    typedef struct packed {
        logic signed [15:0] r0, r1, r2;
        logic [15:0]        a0, a1, a2;
        logic [2:0]         w;
        logic [7:0]         lat;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] pack_ang(input int a0, input int a1, input int a2);
        return {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    // Drives one vector, waits (bounded) for out_valid, returns the observed angles and latency in edges.
    task automatic send(input int r0, input int r1, input int r2,
                        output logic [N*AW-1:0] ang_o, output logic [N-1:0] wf_o, output int lat);
        @(negedge clk);
        in_data  = {DW'(r2), DW'(r1), DW'(r0)};
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = (N*DW)'({$urandom(), $urandom()});
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        ang_o = angle;
        wf_o  = wrap_flag;
        @(posedge clk); #1;
        check("out_valid_single", out_valid, 0);
    endtask

    // Reference: each axis advances by rate modulo FULL_SCALE; every multiple of FULL_SCALE
    // crossed costs one extra cycle.
    task automatic model_vec(input int r0, input int r1, input int r2,
                             output logic [N*AW-1:0] ea, output logic [N-1:0] ew, output int el);
        int r [N];
        int s, k;
        r = '{r0, r1, r2};
        k = 0;
        ew = '0;
        for (int i = 0; i < N; i++) begin
            s = model_ang[i] + r[i];
            if (s < 0) begin
                k += (-s + FSC - 1) / FSC;
                ew[i] = 1'b1;
            end else if (s >= FSC) begin
                k += s / FSC;
                ew[i] = 1'b1;
            end
            model_ang[i] = ((s % FSC) + FSC) % FSC;
        end
        ea = pack_ang(model_ang[0], model_ang[1], model_ang[2]);
        el = 2 * N + k + 1;
    endtask

    task automatic run_model(input int r0, input int r1, input int r2);
        logic [N*AW-1:0] ea, got_a;
        logic [N-1:0]    ew, got_w;
        int              el, got_l;
        model_vec(r0, r1, r2, ea, ew, el);
        send(r0, r1, r2, got_a, got_w, got_l);
        check("rand_angle", got_a, ea);
        check("rand_wrap", got_w, ew);
        check("rand_latency", got_l, el);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*AW-1:0] got_a;
        logic [N-1:0]    got_w;
        int              got_l, hits;

        tbl[0] = '{16'sd10,  16'sd20,  16'sd30,  16'd10,  16'd20,  16'd30, 3'b000, 8'd7};
        tbl[1] = '{16'sd340, 16'sd0,   16'sd0,   16'd350, 16'd20,  16'd30, 3'b000, 8'd7};
        tbl[2] = '{16'sd15,  16'sd0,   16'sd0,   16'd5,   16'd20,  16'd30, 3'b001, 8'd8};
        tbl[3] = '{-16'sd20, 16'sd0,   16'sd0,   16'd345, 16'd20,  16'd30, 3'b001, 8'd8};
        tbl[4] = '{16'sd15,  -16'sd20, -16'sd30, 16'd0,   16'd0,   16'd0,  3'b001, 8'd8};
        tbl[5] = '{16'sd720, 16'sd0,   -16'sd360, 16'd0,  16'd0,   16'd0,  3'b101, 8'd10};
        tbl[6] = '{16'sd359, -16'sd1,  16'sd0,   16'd359, 16'd359, 16'd0,  3'b010, 8'd8};

        repeat (3) @(posedge clk);
        #1;
        check("reset_angle", angle, 0);
        check("reset_wrap", wrap_flag, 0);
        check("reset_out_valid", out_valid, 0);
        @(negedge clk);
        RST = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);

        for (int t = 0; t < 7; t++) begin
            send(tbl[t].r0, tbl[t].r1, tbl[t].r2, got_a, got_w, got_l);
            check($sformatf("tbl%0d_angle", t), got_a, {tbl[t].a2, tbl[t].a1, tbl[t].a0});
            check($sformatf("tbl%0d_wrap", t), got_w, tbl[t].w);
            check($sformatf("tbl%0d_latency", t), got_l, tbl[t].lat);
        end

        // zero while idle clears everything with no strobe
        @(negedge clk);
        zero = 1'b1;
        #1;
        check("zero_idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("zero_idle_angle", angle, 0);
        check("zero_idle_wrap", wrap_flag, 0);
        check("zero_idle_out_valid", out_valid, 0);
        @(negedge clk);
        zero = 1'b0;

        // zero during NORM of axis 1 aborts the vector
        @(negedge clk);
        in_data  = {DW'(7), DW'(6), DW'(5)};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_partial_axis0", angle[AW-1:0], 5);
        @(negedge clk);
        zero = 1'b1;
        @(posedge clk); #1;
        check("abort_angle", angle, 0);
        check("abort_wrap", wrap_flag, 0);
        @(negedge clk);
        zero = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        hits = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        check("abort_no_out_valid", hits, 0);
        model_ang = '{0, 0, 0};

        // asynchronous reset while the adder is busy
        run_model(50, 60, 70);
        @(negedge clk);
        in_data  = {DW'(9), DW'(9), DW'(9)};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        check("rst_mid_angle", angle, 0);
        check("rst_mid_wrap", wrap_flag, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        RST = 1'b1;
        model_ang = '{0, 0, 0};
        send(1, 1, 1, got_a, got_w, got_l);
        check("post_rst_angle", got_a, pack_ang(1, 1, 1));
        check("post_rst_latency", got_l, 7);
        model_ang = '{1, 1, 1};

        for (int v = 0; v < 40; v++) begin
            run_model(int'($urandom_range(0, 1440)) - 720,
                      int'($urandom_range(0, 1440)) - 720,
                      int'($urandom_range(0, 1440)) - 720);
        end

`ifdef GYRO_BIAS_CAL_EN
        @(negedge clk);
        zero = 1'b1;
        @(negedge clk);
        zero = 1'b0;
        cal_start = 1'b1;
        @(posedge clk); #1;
        cal_start = 1'b0;
        check("cal_busy_set", cal_busy, 1);
        hits = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            in_data  = {DW'(0), DW'(-2), DW'(3)};
            in_valid = 1'b1;
            check("cal_in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) hits++;
        end
        check("cal_busy_clear", cal_busy, 0);
        check("cal_no_out_valid", hits, 0);
        check("cal_angle_held", angle, 0);
        send(3, -2, 5, got_a, got_w, got_l);
        check("cal_bias_angle", got_a, pack_ang(0, 0, 5));
        check("cal_bias_wrap", got_w, 0);
        check("cal_bias_latency", got_l, 7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
